// File: rtl/ym2413_bus_writer_if.sv
// Request and pin-level bus bundle for the OPLL host-side write master.
// The master modport is the writer itself; the slave modport is the host
// that issues requests and observes the pins.
interface ym2413_bus_writer_if;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_reg;
  logic [7:0] req_data;
  logic [7:0] bus_d;
  logic       bus_a0;
  logic       bus_cs;
  logic       bus_wr;
  logic       busy;
  logic       done;

  modport master (
    input  req_valid, req_reg, req_data,
    output req_ready, bus_d, bus_a0, bus_cs, bus_wr, busy, done
  );

  modport slave (
    output req_valid, req_reg, req_data,
    input  req_ready, bus_d, bus_a0, bus_cs, bus_wr, busy, done
  );
endinterface

// File: rtl/ym2413_bus_writer.sv
// Host-side OPLL write master: converts a (register, data) request into the
// address strobe / wait / data strobe / wait pin sequence of the core's CPU
// port. All pin outputs come from flops; one shared down-counter times every
// phase and is reloaded on each state entry.
//
// state     | meaning
// ----------+-----------------------------------------------
// S_IDLE    | ready for a request, pins parked at d=0, a0=0
// S_A_SETUP | register address on d, a0=0, strobes low
// S_A_PULSE | cs/wr high for the address write
// S_A_WAIT  | address-write recovery, strobes low
// S_D_SETUP | data value on d, a0=1, strobes low
// S_D_PULSE | cs/wr high for the data write
// S_D_WAIT  | data-write recovery before the next request
module ym2413_bus_writer #(
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int ADDR_WAIT = 12,
  parameter int DATA_WAIT = 84
) (
  input logic                 clk,
  input logic                 rst,
  ym2413_bus_writer_if.master bus
);

  localparam int MAX_AB  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_CD  = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  // Reload values are duration-1 so a phase ends when the counter reads zero.
  localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] LD_PULSE = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] LD_AWAIT = CW'(ADDR_WAIT - 1);
  localparam logic [CW-1:0] LD_DWAIT = CW'(DATA_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_A_SETUP,
    S_A_PULSE,
    S_A_WAIT,
    S_D_SETUP,
    S_D_PULSE,
    S_D_WAIT
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [7:0]    data_q;
  logic          latch_en;
  logic [7:0]    d_q, d_next;
  logic          a0_q, a0_next;
  logic          strb_q, strb_next;
  logic          done_q, done_next;
  logic          cnt_zero;

  assign cnt_zero = (cnt == '0);

  // Every phase must last at least one cycle; a zero-length phase would
  // break the hold guarantee around the strobes.
  param_check: assert property (@(posedge clk)
    (SETUP_CYC >= 1) && (PULSE_CYC >= 1) && (ADDR_WAIT >= 1) && (DATA_WAIT >= 1));

  // Next-state, counter reload and next pin values.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    latch_en   = 1'b0;
    d_next     = d_q;
    a0_next    = a0_q;
    strb_next  = strb_q;
    done_next  = 1'b0;

    case (state)
      S_IDLE: begin
        d_next    = 8'h00;
        a0_next   = 1'b0;
        strb_next = 1'b0;
        if (bus.req_valid) begin
          state_next = S_A_SETUP;
          cnt_next   = LD_SETUP;
          latch_en   = 1'b1;
          d_next     = bus.req_reg;
        end
      end
      S_A_SETUP: begin
        if (cnt_zero) begin
          state_next = S_A_PULSE;
          cnt_next   = LD_PULSE;
          strb_next  = 1'b1;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      S_A_PULSE: begin
        if (cnt_zero) begin
          state_next = S_A_WAIT;
          cnt_next   = LD_AWAIT;
          strb_next  = 1'b0;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      S_A_WAIT: begin
        if (cnt_zero) begin
          state_next = S_D_SETUP;
          cnt_next   = LD_SETUP;
          d_next     = data_q;
          a0_next    = 1'b1;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      S_D_SETUP: begin
        if (cnt_zero) begin
          state_next = S_D_PULSE;
          cnt_next   = LD_PULSE;
          strb_next  = 1'b1;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      S_D_PULSE: begin
        if (cnt_zero) begin
          state_next = S_D_WAIT;
          cnt_next   = LD_DWAIT;
          strb_next  = 1'b0;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      S_D_WAIT: begin
        if (cnt_zero) begin
          state_next = S_IDLE;
          cnt_next   = '0;
          d_next     = 8'h00;
          a0_next    = 1'b0;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
        d_next     = 8'h00;
        a0_next    = 1'b0;
        strb_next  = 1'b0;
      end
    endcase
  end

  // State, counter, latched data and registered pins; reset beats a request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      data_q <= 8'h00;
      d_q    <= 8'h00;
      a0_q   <= 1'b0;
      strb_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      d_q    <= d_next;
      a0_q   <= a0_next;
      strb_q <= strb_next;
      done_q <= done_next;
      if (latch_en) begin
        data_q <= bus.req_data;
      end
    end
  end

  assign bus.req_ready = (state == S_IDLE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.bus_d     = d_q;
  assign bus.bus_a0    = a0_q;
  assign bus.bus_cs    = strb_q;
  assign bus.bus_wr    = strb_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_ym2413_bus_writer.sv
// Bench for ym2413_bus_writer: directed requests push expected strobe and
// completion events into a queue; a negedge monitor pops and compares them
// as the pins show them.
module tb_ym2413_bus_writer;
  localparam int SETUP_CYC = 1;
  localparam int PULSE_CYC = 2;
  localparam int ADDR_WAIT = 12;
  localparam int DATA_WAIT = 84;
  localparam int T_LEN     = 2 * (SETUP_CYC + PULSE_CYC) + ADDR_WAIT + DATA_WAIT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  ym2413_bus_writer_if bif ();

  ym2413_bus_writer #(
    .SETUP_CYC(SETUP_CYC),
    .PULSE_CYC(PULSE_CYC),
    .ADDR_WAIT(ADDR_WAIT),
    .DATA_WAIT(DATA_WAIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         kind;   // 0 = strobe rise, 1 = done pulse
    int         at;
    logic [7:0] d;
    logic       a0;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  bit   skip_fall = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: strobe edges, hold around edges, pulse width, done pulses.
  logic       prev_cs = 1'b0;
  logic [7:0] prev_d  = 8'h00;
  logic       prev_a0 = 1'b0;
  int         width   = 0;

  always @(negedge clk) begin
    exp_t e;
    if (bif.bus_cs !== prev_cs) begin
      chk("cs_eq_wr", {31'b0, bif.bus_wr}, {31'b0, bif.bus_cs});
      if (bif.bus_cs) begin
        chk("hold_rise", {23'b0, bif.bus_a0, bif.bus_d}, {23'b0, prev_a0, prev_d});
        width = 1;
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_strobe: got d=0x%0h a0=%0d expected none (cycle %0d)",
                   bif.bus_d, bif.bus_a0, cyc);
        end else begin
          e = q.pop_front();
          chk("strobe_kind", e.kind, 0);
          chk("strobe_cycle", cyc, e.at);
          chk("strobe_d", {24'b0, bif.bus_d}, {24'b0, e.d});
          chk("strobe_a0", {31'b0, bif.bus_a0}, {31'b0, e.a0});
        end
      end else if (!skip_fall) begin
        chk("pulse_width", width, PULSE_CYC);
        chk("hold_fall", {23'b0, bif.bus_a0, bif.bus_d}, {23'b0, prev_a0, prev_d});
      end
    end else if (bif.bus_cs) begin
      width++;
    end
    if (bif.done) begin
      done_cnt++;
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: got done=1 expected 0 (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        chk("done_kind", e.kind, 1);
        chk("done_cycle", cyc, e.at);
        chk("done_ready", {31'b0, bif.req_ready}, 1);
        chk("idle_d", {24'b0, bif.bus_d}, 0);
        chk("idle_a0", {31'b0, bif.bus_a0}, 0);
      end
    end
    prev_cs = bif.bus_cs;
    prev_d  = bif.bus_d;
    prev_a0 = bif.bus_a0;
  end

  // Issue one request starting at a negedge; returns the accept cycle. The
  // cycle after accept the request fields are scribbled with 0xFF.
  task automatic send(input logic [7:0] r, input logic [7:0] d, output int acc);
    int n = 0;
    bif.req_valid = 1'b1;
    bif.req_reg   = r;
    bif.req_data  = d;
    while (!bif.req_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!bif.req_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: got ready=0 expected 1 (cycle %0d)", cyc);
    end
    acc = cyc;
    q.push_back('{0, acc + 1 + SETUP_CYC, r, 1'b0});
    q.push_back('{0, acc + 1 + 2 * SETUP_CYC + PULSE_CYC + ADDR_WAIT, d, 1'b1});
    q.push_back('{1, acc + T_LEN + 1, 8'h00, 1'b0});
    @(negedge clk);
    bif.req_valid = 1'b0;
    bif.req_reg   = 8'hFF;
    bif.req_data  = 8'hFF;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, a3, n, dc;
    bif.req_valid = 1'b0;
    bif.req_reg   = 8'h00;
    bif.req_data  = 8'h00;

    // Reset then idle.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_d", {24'b0, bif.bus_d}, 0);
    chk("rst_a0", {31'b0, bif.bus_a0}, 0);
    chk("rst_cs", {31'b0, bif.bus_cs}, 0);
    chk("rst_wr", {31'b0, bif.bus_wr}, 0);
    chk("rst_ready", {31'b0, bif.req_ready}, 1);
    chk("rst_busy", {31'b0, bif.busy}, 0);
    chk("rst_done", {31'b0, bif.done}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single write; fields overwritten with 0xFF after accept.
    send(8'h10, 8'hAB, a1);
    chk("busy_after_accept", {31'b0, bif.busy}, 1);
    chk("ready_after_accept", {31'b0, bif.req_ready}, 0);
    drain();

    // Back-to-back with the request held.
    send(8'h30, 8'h11, a1);
    send(8'h20, 8'h1C, a2);
    chk("b2b_period", a2 - a1, T_LEN + 1);
    drain();

    // Reset together with a request: reset wins.
    rst = 1'b1;
    bif.req_valid = 1'b1;
    bif.req_reg   = 8'h77;
    bif.req_data  = 8'h88;
    @(negedge clk);
    rst = 1'b0;
    bif.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rstvalid_d", {24'b0, bif.bus_d}, 0);
    chk("rstvalid_ready", {31'b0, bif.req_ready}, 1);

    // Reset during the data strobe abandons the write.
    send(8'h55, 8'h66, a3);
    n = 0;
    while (!(bif.bus_cs && bif.bus_a0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reach_d_pulse", {31'b0, bif.bus_cs && bif.bus_a0}, 1);
    skip_fall = 1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_cs", {31'b0, bif.bus_cs}, 0);
    chk("midrst_wr", {31'b0, bif.bus_wr}, 0);
    chk("midrst_d", {24'b0, bif.bus_d}, 0);
    chk("midrst_ready", {31'b0, bif.req_ready}, 1);
    rst = 1'b0;
    q.delete();
    dc = done_cnt;
    repeat (120) @(negedge clk);
    chk("midrst_no_done", done_cnt, dc);
    skip_fall = 0;

    // Normal operation resumes after the abandoned write.
    send(8'h0E, 8'h20, a3);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ym2413_bus_writer.md
Name: ym2413_bus_writer

Overview:
- Host-side bus master for the OPLL core's CPU write port: turns (register, data) write requests into the two-phase A0/CS/WR/D pin sequence the core's bus responder expects.
- Inserts the mandatory post-write wait times: 12 master clocks after an address write, 84 after a data write.
- Sits in the test/host harness, or in a companion tile, that drives the chip's ui_in / uio_in pins; clk equals the core's master clock (phiM).

Parameters:
- SETUP_CYC, 1: cycles D/A0 are stable before CS/WR assert (>=1)
- PULSE_CYC, 2: cycles CS and WR are held asserted (>=1)
- ADDR_WAIT, 12: cycles after address strobe before data phase (>=1)
- DATA_WAIT, 84: cycles after data strobe before next request may start (>=1)

Ports:
- clk, in, 1: clock, same as the core master clock
- rst, in, 1: synchronous, active-high reset
- req_valid, in, 1: write request present
- req_ready, out, 1: block can accept a request
- req_reg, in, 8: OPLL register address
- req_data, in, 8: value to write
- bus_d, out, 8: to DIN pins (ui_in)
- bus_a0, out, 1: to A0 (uio_in[0]); 0 = address, 1 = data
- bus_cs, out, 1: chip select, active-high (pin convention; the core inverts it)
- bus_wr, out, 1: write strobe, active-high
- busy, out, 1: transaction in flight (= ~req_ready)
- done, out, 1: one-cycle pulse when a transaction completes

Behaviour:
- Reset (rst=1 at a posedge): next-cycle outputs are bus_d=0x00, bus_a0=0, bus_cs=0, bus_wr=0, req_ready=1, busy=0, done=0. All counters cleared.
- All bus outputs are registered; no combinational path from req_* to bus_*.
- Accept: when req_valid & req_ready are both high at a posedge, req_reg and req_data are latched. Later changes on req_* are ignored until the next accept. req_ready=1 only in IDLE.
- FSM states and durations:
  - IDLE: wait for accept.
  - A_SETUP, SETUP_CYC cycles: bus_d=reg, bus_a0=0, cs=wr=0.
  - A_PULSE, PULSE_CYC cycles: cs=wr=1, d/a0 unchanged.
  - A_WAIT, ADDR_WAIT cycles: cs=wr=0, d/a0 held.
  - D_SETUP, SETUP_CYC cycles: bus_d=data, bus_a0=1, cs=wr=0.
  - D_PULSE, PULSE_CYC cycles: cs=wr=1.
  - D_WAIT, DATA_WAIT cycles: cs=wr=0, d/a0 held.
  - Then back to IDLE.
- bus_cs and bus_wr always toggle together. D and A0 never change in the cycle cs/wr rises or falls, so there is at least 1 cycle of hold.
- Latency: the first A_SETUP cycle is visible the cycle after accept. Transaction length T = 2*(SETUP_CYC+PULSE_CYC)+ADDR_WAIT+DATA_WAIT (defaults: 102).
- done=1 and req_ready=1 together in the first IDLE cycle after D_WAIT.
- Back-to-back: a request held valid is accepted in that same cycle. Accept-to-accept period is T+1 (defaults: 103).
- On return to IDLE, bus_d returns to 0x00 and bus_a0 to 0.
- Counter: a single down-counter sized for max(params), reloaded at each state entry. Zero-length states are not permitted (parameter >=1 asserted in simulation).
- Reset mid-transaction: abandons the write. If cs/wr were asserted they drop at the next edge. No done pulse.
- rst and req_valid together: rst wins, and the request is not accepted.

Test Plan:
- Reset then idle: rst high 2 cycles -> bus_d=0x00, a0=0, cs=wr=0, req_ready=1, done=0.
- Single write reg=0x10, data=0xAB (defaults), accept at cycle 0:
  - cycle 1: d=0x10, a0=0, cs=wr=0
  - cycles 2-3: cs=wr=1
  - cycles 4-15: cs=wr=0
  - cycle 16: d=0xAB, a0=1
  - cycles 17-18: cs=wr=1
  - cycles 19-102: wait
  - cycle 103: done=1, ready=1
- Back-to-back writes (0x30,0x11) then (0x20,0x1C) with req_valid held -> second accept exactly 103 cycles after first; second address strobe starts at cycle 105.
- req_reg/req_data changed to 0xFF the cycle after accept -> bus still shows the originally latched 0x10/0xAB.
- rst asserted during D_PULSE -> next cycle cs=wr=0, d=0x00, ready=1, no done pulse.
- End-to-end with the OPLL core at defaults: write 0x10=0xAB, 0x30=0x0F, 0x20=0x1C -> core registers read back as written and channel 0 produces non-zero output samples.
